pipeline_stall_ctrl: RTL and testbench
======================================

// Module: pipeline_stall_ctrl
// PURPOSE
//   Central stall/flush sequencer for the 5-stage pipeline (IF/ID/EX/MEM/WB).
//   - Merges the single-cycle load-use request, multi-cycle mult/div occupancy, memory-bus wait
//     and MEM-stage exceptions.
//   - Drives one priority-resolved set of per-stage write-enable, bubble and flush controls.
//   - Sits between the hazard detector, the HI/LO mult/div unit, the memory interface and the
//     pipeline registers.
// PARAMETERS
//   MULT_CYCLES  4   EX-issue-to-HI/LO-valid latency of multiply, cycles (1..63)
//   DIV_CYCLES   32  EX-issue-to-HI/LO-valid latency of divide, cycles (1..63)
//   CNT_W        6   width of mult/div countdown; must hold max(MULT_CYCLES,DIV_CYCLES)
// PORTS
//   clock          in   1  pipeline clock, rising edge
//   rst_n          in   1  asynchronous active-low reset
//   load_use       in   1  load-use hazard detected (ID needs EX load result)
//   branch_taken   in   1  ID-stage branch/jump resolved taken
//   md_start       in   1  EX issues mult/div this cycle (qualified by EX valid)
//   md_is_div      in   1  with md_start: 1=divide, 0=multiply
//   id_uses_hilo   in   1  ID instruction reads HI/LO or issues mult/div
//   mem_req        in   1  MEM stage has an active load/store
//   mem_ready      in   1  memory bus completes the MEM access this cycle
//   exc_req        in   1  MEM-stage exception/interrupt taken
//   pc_write       out  1  PC register load enable
//   if_id_write    out  1  IF/ID register load enable
//   if_id_flush    out  1  IF/ID cleared to NOP at next edge
//   id_ex_bubble   out  1  ID/EX loads NOP at next edge
//   ex_mem_hold    out  1  EX/MEM holds its contents
//   ex_mem_flush   out  1  EX/MEM cleared to NOP at next edge
//   mem_wb_bubble  out  1  MEM/WB loads NOP at next edge
//   exc_pc_sel     out  1  PC loads exception vector at next edge
//   md_busy        out  1  mult/div result not yet valid in HI/LO
// BEHAVIOUR
//   State register (3 states): RUN, MEM_WAIT, MD_WAIT. Countdown md_cnt [CNT_W-1:0].
//   Outputs are Mealy (state + current inputs), so a stall takes effect at the same clock edge
//   its cause is seen.
//   Reset (rst_n=0, async):
//     - Registers: state=RUN, md_cnt=0.
//     - Outputs while asserted: pc_write=0, if_id_write=0; every other output=0.
//   Default (RUN, no request): pc_write=1, if_id_write=1; all bubble/flush/hold/sel=0.
//   Priority, highest first; a higher cause masks all lower ones in that cycle:
//   1. exc_req (any state):
//      - Outputs: exc_pc_sel=1, pc_write=1; if_id_flush=id_ex_bubble=ex_mem_flush=1; mem_wb_bubble=1.
//      - Next state RUN; md_cnt cleared to 0 (in-flight mult/div abandoned).
//   2. mem_req & !mem_ready:
//      - Outputs: pc_write=0, if_id_write=0, id_ex_bubble=0, ex_mem_hold=1, mem_wb_bubble=1.
//      - Next state MEM_WAIT; remain there while !mem_ready.
//      - On mem_ready: RUN outputs that cycle; next state RUN.
//   3. md_busy & id_uses_hilo:
//      - Outputs: pc_write=0, if_id_write=0, id_ex_bubble=1.
//      - Next state MD_WAIT; leave to RUN in the cycle md_cnt reaches 0.
//   4. load_use: pc_write=0, if_id_write=0, id_ex_bubble=1 for exactly that cycle; no state change.
//   5. branch_taken: if_id_flush=1 (delay-slot-free squash of the fetched instruction).
//   Suppression rules:
//     - branch_taken is ignored in any cycle where rule 2, 3 or 4 stalls ID; it re-presents
//       after the stall.
//     - md_start is ignored while rule 1 or 2 is active (EX is frozen or squashed).
//   md_cnt:
//     - Load: md_start (not suppressed) & md_cnt==0 loads MULT_CYCLES or DIV_CYCLES per md_is_div.
//     - Count: otherwise md_cnt decrements by 1 while nonzero, including during MEM_WAIT.
//     - md_busy = (md_cnt!=0). Saturates at 0; never wraps.
//     - md_start while md_cnt!=0 is ignored (cannot occur legally, because rule 3 stalls ID).
//   Mid-operation reset: returns to reset values immediately; any pending stall is dropped.
// STRUCTURE
//   - Shared package pipe_ctrl_pkg holds the state encoding localparams (RUN=0, MEM_WAIT=1,
//     MD_WAIT=2) and the default MULT_CYCLES/DIV_CYCLES constants.
//   - One sub-module, md_latency_counter (load/decrement/busy), instantiated once.
//   - Everything else lives here: state FSM and the priority output logic.
// TESTING
//   1. Release rst_n, then idle 3 cycles -> pc_write=1, if_id_write=1, all other outputs 0,
//      md_busy=0.
//   2. load_use=1 for 1 cycle -> pc_write=0, id_ex_bubble=1 that cycle only; next cycle
//      defaults again.
//   3. md_start=1, md_is_div=1, then id_uses_hilo=1 held -> md_busy high 32 cycles; ID stalled
//      until md_cnt=0, then pc_write=1.
//   4. mem_req=1, mem_ready=0 for 5 cycles, then 1 -> ex_mem_hold=1, mem_wb_bubble=1 for 5
//      cycles; state returns to RUN.
//   5. exc_req=1 during MEM_WAIT with md_cnt=10 -> exc_pc_sel=1 and all flushes=1 that cycle;
//      next cycle RUN with md_busy=0.
//   6. branch_taken=1 with load_use=1 same cycle -> if_id_flush=0, id_ex_bubble=1; then
//      branch_taken alone -> if_id_flush=1.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Holds the FSM state encoding, default mult/div latencies and the packed control word.
package pipe_ctrl_pkg;

  localparam int MULT_CYCLES_DEF = 4;
  localparam int DIV_CYCLES_DEF  = 32;
  localparam int CNT_W_DEF       = 6;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MD_WAIT  = 2'd2
  } state_t;

  // One field per pipeline-register control line driven by the sequencer.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic ex_mem_hold;
    logic ex_mem_flush;
    logic mem_wb_bubble;
    logic exc_pc_sel;
  } ctrl_t;

  localparam ctrl_t CTRL_OFF = '0;

  localparam ctrl_t CTRL_RUN = '{
    pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0, id_ex_bubble: 1'b0,
    ex_mem_hold: 1'b0, ex_mem_flush: 1'b0, mem_wb_bubble: 1'b0, exc_pc_sel: 1'b0
  };

  // Exception squashes IF/ID/EX/MEM and redirects the PC to the vector.
  localparam ctrl_t CTRL_EXC = '{
    pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1, id_ex_bubble: 1'b1,
    ex_mem_hold: 1'b0, ex_mem_flush: 1'b1, mem_wb_bubble: 1'b1, exc_pc_sel: 1'b1
  };

  // Memory wait freezes everything upstream of MEM and drains a bubble into WB.
  localparam ctrl_t CTRL_MEM = '{
    pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0, id_ex_bubble: 1'b0,
    ex_mem_hold: 1'b1, ex_mem_flush: 1'b0, mem_wb_bubble: 1'b1, exc_pc_sel: 1'b0
  };

  // ID stall: hold PC and IF/ID, inject a bubble into EX.
  localparam ctrl_t CTRL_ID_STALL = '{
    pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0, id_ex_bubble: 1'b1,
    ex_mem_hold: 1'b0, ex_mem_flush: 1'b0, mem_wb_bubble: 1'b0, exc_pc_sel: 1'b0
  };

endpackage

// File: rtl/md_latency_counter.sv
// Countdown tracking how long until an issued mult/div result lands in HI/LO.
// Loads on an accepted start, decrements to zero, never wraps.
module md_latency_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic clock,
  input  logic rst_n,
  input  logic start,
  input  logic is_div,
  input  logic clear,
  output logic busy
);

  logic [CNT_W-1:0] cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (start && (cnt == '0)) begin
      cnt <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Resolves exception, memory wait, HI/LO and load-use hazards into one set of stage controls.
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic clock,
  input  logic rst_n,
  input  logic load_use,
  input  logic branch_taken,
  input  logic md_start,
  input  logic md_is_div,
  input  logic id_uses_hilo,
  input  logic mem_req,
  input  logic mem_ready,
  input  logic exc_req,
  output logic pc_write,
  output logic if_id_write,
  output logic if_id_flush,
  output logic id_ex_bubble,
  output logic ex_mem_hold,
  output logic ex_mem_flush,
  output logic mem_wb_bubble,
  output logic exc_pc_sel,
  output logic md_busy
);

  state_t state;
  state_t state_nxt;
  ctrl_t  ctrl;
  logic   md_busy_int;
  logic   mem_stall;
  logic   md_stall;
  logic   md_accept;

  // An access already parked in MEM_WAIT keeps the stall until the bus answers.
  assign mem_stall = !exc_req && !mem_ready && (mem_req || (state == MEM_WAIT));
  assign md_stall  = !exc_req && !mem_stall && md_busy_int && id_uses_hilo;
  assign md_accept = md_start && !exc_req && !mem_stall;

  md_latency_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_cnt (
    .clock  (clock),
    .rst_n  (rst_n),
    .start  (md_accept),
    .is_div (md_is_div),
    .clear  (exc_req),
    .busy   (md_busy_int)
  );

  always_comb begin
    // NOTE: defaults first so no path through this block leaves a signal unassigned (no latches).
    state_nxt = RUN;
    if (exc_req) begin
      state_nxt = RUN;
    end else if (mem_stall) begin
      state_nxt = MEM_WAIT;
    end else if (md_stall) begin
      state_nxt = MD_WAIT;
    end
  end

  // NOTE: only the FSM state is reset here; control outputs are combinational and forced low in reset.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Priority chain: a higher cause masks everything below it in the same cycle.
  always_comb begin
    ctrl = CTRL_RUN;
    if (exc_req) begin
      ctrl = CTRL_EXC;
    end else if (mem_stall) begin
      ctrl = CTRL_MEM;
    end else if (md_stall || load_use) begin
      ctrl = CTRL_ID_STALL;
    end else if (branch_taken) begin
      ctrl.if_id_flush = 1'b1;
    end
    if (!rst_n) begin
      ctrl = CTRL_OFF;
    end
  end

  assign pc_write      = ctrl.pc_write;
  assign if_id_write   = ctrl.if_id_write;
  assign if_id_flush   = ctrl.if_id_flush;
  assign id_ex_bubble  = ctrl.id_ex_bubble;
  assign ex_mem_hold   = ctrl.ex_mem_hold;
  assign ex_mem_flush  = ctrl.ex_mem_flush;
  assign mem_wb_bubble = ctrl.mem_wb_bubble;
  assign exc_pc_sel    = ctrl.exc_pc_sel;
  assign md_busy       = rst_n && md_busy_int;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl with default latencies (mult 4, div 32).
// Output vector order: pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_hold, ex_mem_flush, mem_wb_bubble, exc_pc_sel, md_busy.
module tb_pipeline_stall_ctrl;

  localparam logic [8:0] O_ZERO  = 9'b000000000;
  localparam logic [8:0] O_RUN   = 9'b110000000;
  localparam logic [8:0] O_STALL = 9'b000100000;
  localparam logic [8:0] O_MEM   = 9'b000010100;
  localparam logic [8:0] O_EXC   = 9'b111101110;
  localparam logic [8:0] O_BR    = 9'b111000000;
  localparam logic [8:0] BUSY    = 9'b000000001;

  logic clock = 1'b0;
  logic rst_n;
  logic load_use, branch_taken, md_start, md_is_div, id_uses_hilo;
  logic mem_req, mem_ready, exc_req;
  logic pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_hold;
  logic ex_mem_flush, mem_wb_bubble, exc_pc_sel, md_busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  pipeline_stall_ctrl dut (
    .clock         (clock),
    .rst_n         (rst_n),
    .load_use      (load_use),
    .branch_taken  (branch_taken),
    .md_start      (md_start),
    .md_is_div     (md_is_div),
    .id_uses_hilo  (id_uses_hilo),
    .mem_req       (mem_req),
    .mem_ready     (mem_ready),
    .exc_req       (exc_req),
    .pc_write      (pc_write),
    .if_id_write   (if_id_write),
    .if_id_flush   (if_id_flush),
    .id_ex_bubble  (id_ex_bubble),
    .ex_mem_hold   (ex_mem_hold),
    .ex_mem_flush  (ex_mem_flush),
    .mem_wb_bubble (mem_wb_bubble),
    .exc_pc_sel    (exc_pc_sel),
    .md_busy       (md_busy)
  );

  function automatic logic [8:0] outs();
    return {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_hold,
            ex_mem_flush, mem_wb_bubble, exc_pc_sel, md_busy};
  endfunction

  task automatic clear_inputs();
    load_use = 0; branch_taken = 0; md_start = 0; md_is_div = 0;
    id_uses_hilo = 0; mem_req = 0; mem_ready = 0; exc_req = 0;
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1 time unit later.
  task automatic next_cycle();
    @(negedge clock);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    exc_req = 1; mem_req = 1; load_use = 1; branch_taken = 1;
    #2;
    vectors++;
    if (outs() !== O_ZERO) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b expected %b", outs(), O_ZERO);
    end
    next_cycle();
    clear_inputs();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      #1;
      vectors++;
      if (outs() !== O_RUN) begin
        miscompares++;
        $display("FAIL idle_after_reset[%0d]: got %b expected %b", i, outs(), O_RUN);
      end
    end
  endtask

  task automatic test_load_use();
    next_cycle();
    load_use = 1;
    #1;
    vectors++;
    if (outs() !== O_STALL) begin
      miscompares++;
      $display("FAIL load_use_stall: got %b expected %b", outs(), O_STALL);
    end
    next_cycle();
    load_use = 0;
    #1;
    vectors++;
    if (outs() !== O_RUN) begin
      miscompares++;
      $display("FAIL load_use_release: got %b expected %b", outs(), O_RUN);
    end
  endtask

  task automatic test_md_stall(input logic div, input int exp_len);
    int stalls;
    next_cycle();
    md_start = 1; md_is_div = div;
    #1;
    vectors++;
    if (outs() !== O_RUN) begin
      miscompares++;
      $display("FAIL md_issue(div=%0b): got %b expected %b", div, outs(), O_RUN);
    end
    next_cycle();
    md_start = 0; md_is_div = 0; id_uses_hilo = 1;
    #1;
    stalls = 0;
    while (pc_write !== 1'b1 && stalls < 100) begin
      vectors++;
      if (outs() !== (O_STALL | BUSY)) begin
        miscompares++;
        $display("FAIL md_stall_cycle(div=%0b,%0d): got %b expected %b", div, stalls, outs(), O_STALL | BUSY);
      end
      stalls++;
      next_cycle();
      #1;
    end
    vectors++;
    if (stalls !== exp_len) begin
      miscompares++;
      $display("FAIL md_stall_length(div=%0b): got %0d expected %0d", div, stalls, exp_len);
    end
    vectors++;
    if (outs() !== O_RUN) begin
      miscompares++;
      $display("FAIL md_release(div=%0b): got %b expected %b", div, outs(), O_RUN);
    end
    next_cycle();
    id_uses_hilo = 0;
  endtask

  task automatic test_mem_wait();
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      mem_req = 1; mem_ready = 0; md_start = (i == 0);
      #1;
      vectors++;
      if (outs() !== O_MEM) begin
        miscompares++;
        $display("FAIL mem_wait[%0d]: got %b expected %b", i, outs(), O_MEM);
      end
    end
    next_cycle();
    md_start = 0; mem_ready = 1;
    #1;
    vectors++;
    if (outs() !== O_RUN) begin
      miscompares++;
      $display("FAIL mem_ready_cycle: got %b expected %b", outs(), O_RUN);
    end
    next_cycle();
    mem_req = 0; mem_ready = 0;
    #1;
    vectors++;
    if (outs() !== O_RUN) begin
      miscompares++;
      $display("FAIL mem_back_to_run: got %b expected %b", outs(), O_RUN);
    end
  endtask

  task automatic test_md_during_mem();
    next_cycle();
    md_start = 1; md_is_div = 0;
    #1;
    vectors++;
    if (outs() !== O_RUN) begin
      miscompares++;
      $display("FAIL mult_issue_pre_mem: got %b expected %b", outs(), O_RUN);
    end
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      md_start = 0; mem_req = 1; mem_ready = 0;
      #1;
      vectors++;
      if (outs() !== (O_MEM | BUSY)) begin
        miscompares++;
        $display("FAIL mult_count_in_mem[%0d]: got %b expected %b", i, outs(), O_MEM | BUSY);
      end
    end
    next_cycle();
    mem_ready = 1;
    #1;
    vectors++;
    if (outs() !== O_RUN) begin
      miscompares++;
      $display("FAIL mult_done_at_mem_ready: got %b expected %b", outs(), O_RUN);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_exc_in_mem_wait();
    next_cycle();
    md_start = 1; md_is_div = 1;
    #1;
    vectors++;
    if (outs() !== O_RUN) begin
      miscompares++;
      $display("FAIL div_issue_pre_exc: got %b expected %b", outs(), O_RUN);
    end
    for (int j = 1; j <= 22; j++) begin
      next_cycle();
      md_start = 0; md_is_div = 0;
      mem_req = (j >= 20); mem_ready = 0;
      #1;
      vectors++;
      if (outs() !== ((j >= 20) ? (O_MEM | BUSY) : (O_RUN | BUSY))) begin
        miscompares++;
        $display("FAIL div_countdown[%0d]: got %b expected %b", j, outs(),
                 (j >= 20) ? (O_MEM | BUSY) : (O_RUN | BUSY));
      end
    end
    next_cycle();
    exc_req = 1;
    #1;
    vectors++;
    if (outs() !== (O_EXC | BUSY)) begin
      miscompares++;
      $display("FAIL exc_in_mem_wait: got %b expected %b", outs(), O_EXC | BUSY);
    end
    next_cycle();
    clear_inputs();
    id_uses_hilo = 1;
    #1;
    vectors++;
    if (outs() !== O_RUN) begin
      miscompares++;
      $display("FAIL after_exc: got %b expected %b", outs(), O_RUN);
    end
    next_cycle();
    id_uses_hilo = 0;
  endtask

  task automatic test_branch();
    logic [8:0] exp_tab [5];
    exp_tab = '{O_STALL, O_BR, O_MEM, O_BR, O_EXC};
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      branch_taken = 1;
      load_use  = (i == 0);
      mem_req   = (i == 2) || (i == 3);
      mem_ready = (i == 3);
      exc_req   = (i == 4);
      #1;
      vectors++;
      if (outs() !== exp_tab[i]) begin
        miscompares++;
        $display("FAIL branch_case[%0d]: got %b expected %b", i, outs(), exp_tab[i]);
      end
    end
    next_cycle();
    clear_inputs();
    #1;
    vectors++;
    if (outs() !== O_RUN) begin
      miscompares++;
      $display("FAIL branch_release: got %b expected %b", outs(), O_RUN);
    end
  endtask

  task automatic test_reset_mid();
    next_cycle();
    md_start = 1; md_is_div = 1;
    next_cycle();
    md_start = 0; md_is_div = 0; mem_req = 1; mem_ready = 0;
    #1;
    vectors++;
    if (outs() !== (O_MEM | BUSY)) begin
      miscompares++;
      $display("FAIL pre_reset_stall: got %b expected %b", outs(), O_MEM | BUSY);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (outs() !== O_ZERO) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: got %b expected %b", outs(), O_ZERO);
    end
    next_cycle();
    clear_inputs();
    rst_n = 1'b1;
    id_uses_hilo = 1;
    #1;
    vectors++;
    if (outs() !== O_RUN) begin
      miscompares++;
      $display("FAIL after_mid_reset: got %b expected %b", outs(), O_RUN);
    end
    next_cycle();
    clear_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_load_use();
    test_md_stall(1'b0, 4);
    test_md_stall(1'b1, 32);
    test_mem_wait();
    test_md_during_mem();
    test_exc_in_mem_wait();
    test_branch();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
